cpu_run_ctrl: RTL and testbench

//  Parametrised execution controller for the pipelined MIPS core, between board inputs and
//  the CPU. Stretches reset requests and gates the CPU with a clock enable.
//  Run modes: free-run, N-cycle burst step, and halt on up to N_BKPT PC breakpoints.

---
 rtl/cpu_run_ctrl_if.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Board-side request/status bundle for the CPU execution controller.
// master = board/debug side driving requests, slave = controller.
interface cpu_run_ctrl_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 8,
    parameter int unsigned N_BKPT      = 2
);
    logic                         rst_req;
    logic                         step_req;
    logic                         run_req;
    logic [BURST_WIDTH-1:0]       burst_len;
    logic [N_BKPT-1:0]            bkpt_en;
    logic [N_BKPT*ADDR_WIDTH-1:0] bkpt_addr;
    logic [ADDR_WIDTH-1:0]        pc;
    logic                         cpu_rst;
    logic                         cpu_en;
    logic                         halted;
    logic [N_BKPT-1:0]            bkpt_hit;
    logic [31:0]                  cycle_count;

    modport master (
        output rst_req, step_req, run_req, burst_len, bkpt_en, bkpt_addr, pc,
        input  cpu_rst, cpu_en, halted, bkpt_hit, cycle_count
    );

    modport slave (
        input  rst_req, step_req, run_req, burst_len, bkpt_en, bkpt_addr, pc,
        output cpu_rst, cpu_en, halted, bkpt_hit, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the pipelined MIPS core: reset stretching, free-run,
// burst stepping and PC breakpoints, gating the core through a clock enable.
module cpu_run_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 8,
    parameter int unsigned RST_STRETCH = 16,
    parameter int unsigned N_BKPT      = 2
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RESET,
        S_HALT,
        S_RUN,
        S_BURST
    } state_t;

    state_t                 r_state;
    logic [RST_STRETCH-1:0] r_stretch;
    logic                   r_cpu_rst;
    logic [BURST_WIDTH-1:0] r_cnt;
    logic                   r_skip;
    logic                   r_step_d;
    logic                   r_run_d;
    logic [N_BKPT-1:0]      r_bkpt_hit;
    logic [31:0]            r_cycle_count;

    logic [N_BKPT-1:0]      w_match_vec;
    logic                   w_bkpt_match;
    logic                   w_step_rise;
    logic                   w_run_rise;
    logic                   w_cpu_en;
    logic [BURST_WIDTH-1:0] w_burst_load;

    always_comb begin
        w_match_vec = '0;
        for (int unsigned i = 0; i < N_BKPT; i++) begin
            w_match_vec[i] = bus.bkpt_en[i] &&
                             (bus.pc == bus.bkpt_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // skip masks the comparators for the first enabled cycle after a resume,
    // so restarting on a breakpoint PC executes that instruction.
    assign w_bkpt_match = (|w_match_vec) && !r_skip;
    assign w_step_rise  = bus.step_req && !r_step_d;
    assign w_run_rise   = bus.run_req && !r_run_d;
    assign w_cpu_en     = ((r_state == S_RUN) || (r_state == S_BURST)) &&
                          !w_bkpt_match && !r_cpu_rst;
    assign w_burst_load = (bus.burst_len == '0) ? BURST_WIDTH'(1) : bus.burst_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RESET;
            r_stretch     <= '1;
            r_cpu_rst     <= 1'b1;
            r_cnt         <= '0;
            r_skip        <= 1'b0;
            r_step_d      <= 1'b0;
            r_run_d       <= 1'b0;
            r_bkpt_hit    <= '0;
            r_cycle_count <= '0;
        end else begin
            r_step_d  <= bus.step_req;
            r_run_d   <= bus.run_req;
            r_cpu_rst <= |r_stretch;

            if (bus.rst_req) begin
                r_stretch <= '1;
            end else begin
                r_stretch <= {r_stretch[RST_STRETCH-2:0], 1'b0};
            end

            if (w_cpu_en) begin
                r_cycle_count <= r_cycle_count + 32'd1;
                r_skip        <= 1'b0;
            end

            if (bus.rst_req) begin
                r_state <= S_RESET;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_RESET: begin
                        if (r_stretch == '0) begin
                            r_state <= S_HALT;
                        end
                    end
                    S_HALT: begin
                        if (w_run_rise) begin
                            r_state    <= S_RUN;
                            r_bkpt_hit <= '0;
                            r_skip     <= 1'b1;
                        end else if (w_step_rise) begin
                            r_state    <= S_BURST;
                            r_cnt      <= w_burst_load;
                            r_bkpt_hit <= '0;
                            r_skip     <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_bkpt_match) begin
                            r_state    <= S_HALT;
                            r_bkpt_hit <= r_bkpt_hit | w_match_vec;
                        end else if (!bus.run_req) begin
                            r_state <= S_HALT;
                        end
                    end
                    S_BURST: begin
                        if (w_bkpt_match) begin
                            r_state    <= S_HALT;
                            r_bkpt_hit <= r_bkpt_hit | w_match_vec;
                            r_cnt      <= '0;
                        end else if (w_cpu_en) begin
                            r_cnt <= r_cnt - BURST_WIDTH'(1);
                            if (r_cnt == BURST_WIDTH'(1)) begin
                                r_state <= S_HALT;
                            end
                        end
                    end
                    default: r_state <= S_RESET;
                endcase
            end
        end
    end

    assign bus.cpu_rst     = r_cpu_rst;
    assign bus.cpu_en      = w_cpu_en;
    assign bus.halted      = (r_state == S_RESET) || (r_state == S_HALT);
    assign bus.bkpt_hit    = r_bkpt_hit;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: comparator table plus hand-written run/step/reset sequences.
module tb_cpu_run_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.ADDR_WIDTH(32), .BURST_WIDTH(8), .N_BKPT(2)) bus ();

    cpu_run_ctrl #(
        .ADDR_WIDTH (32),
        .BURST_WIDTH(8),
        .RST_STRETCH(16),
        .N_BKPT     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  en;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] pc;
        logic        exp_en;
    } vec_t;

    vec_t        vecs[11];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] pc_m;
    logic        last_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One clock: cpu_en sampled mid-cycle, bench PC model advances on enabled cycles.
    task automatic tick();
        @(negedge clk);
        last_en = bus.cpu_en;
        @(posedge clk);
        #1;
        if (last_en) pc_m = pc_m + 32'd4;
        bus.pc = pc_m;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned cnt_a;
        int unsigned cnt_b;
        logic [7:0]  mask;

        vecs[0]  = '{2'b00, 32'h40, 32'h80, 32'h40, 1'b1};
        vecs[1]  = '{2'b01, 32'h40, 32'h80, 32'h40, 1'b0};
        vecs[2]  = '{2'b01, 32'h40, 32'h80, 32'h80, 1'b1};
        vecs[3]  = '{2'b10, 32'h40, 32'h80, 32'h80, 1'b0};
        vecs[4]  = '{2'b10, 32'h40, 32'h80, 32'h40, 1'b1};
        vecs[5]  = '{2'b11, 32'h40, 32'h80, 32'h80, 1'b0};
        vecs[6]  = '{2'b11, 32'h40, 32'h80, 32'h44, 1'b1};
        vecs[7]  = '{2'b11, 32'h40, 32'h40, 32'h40, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0};
        vecs[9]  = '{2'b10, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[10] = '{2'b01, 32'h40, 32'h0, 32'h41, 1'b1};

        rst           = 1'b1;
        bus.rst_req   = 1'b0;
        bus.step_req  = 1'b0;
        bus.run_req   = 1'b0;
        bus.burst_len = 8'd0;
        bus.bkpt_en   = 2'b00;
        bus.bkpt_addr = '0;
        pc_m          = 32'h1000;
        bus.pc        = pc_m;
        last_en       = 1'b0;

        // Reset state and stretch length after a one-cycle rst
        tick();
        check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("rst_halted", 32'(bus.halted), 32'd1);
        check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("rst_bkpt_hit", 32'(bus.bkpt_hit), 32'd0);
        check("rst_cycle_count", bus.cycle_count, 32'd0);
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cpu_rst) cnt_a++;
            if (last_en || !bus.halted) cnt_b++;
        end
        check("t1_cpu_rst_len", cnt_a, 32'd16);
        check("t1_en_or_running", cnt_b, 32'd0);
        check("t1_cpu_rst_low", 32'(bus.cpu_rst), 32'd0);

        // Comparator table, applied mid-cycle while in RUN
        bus.run_req = 1'b1;
        tick();
        check("run_entered", 32'(bus.halted), 32'd0);
        tick();
        foreach (vecs[k]) begin
            @(negedge clk);
            bus.bkpt_en   = vecs[k].en;
            bus.bkpt_addr = {vecs[k].a1, vecs[k].a0};
            bus.pc        = vecs[k].pc;
            #1;
            check($sformatf("table_en_%0d", k), 32'(bus.cpu_en), 32'(vecs[k].exp_en));
            #1;
            bus.bkpt_en = 2'b00;
            bus.pc      = pc_m;
        end
        tick();
        check("table_still_running", 32'(bus.halted), 32'd0);
        bus.run_req = 1'b0;

        // Fresh reset so the cycle counter and PC start from known values
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        pc_m = 32'h0;
        bus.pc = pc_m;
        for (int i = 0; i < 18; i++) tick();
        check("rerst_halted", 32'(bus.halted), 32'd1);
        check("rerst_cycle_count", bus.cycle_count, 32'd0);

        // Burst of 5
        bus.burst_len = 8'd5;
        bus.step_req  = 1'b1;
        tick();
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mask[i] = last_en;
            if (i == 2) bus.step_req = 1'b0;
        end
        check("t2_en_pattern", 32'(mask), 32'h1F);
        check("t2_cycle_count", bus.cycle_count, 32'd5);
        check("t2_halted", 32'(bus.halted), 32'd1);

        // burst_len=0 gives a single cycle
        bus.burst_len = 8'd0;
        bus.step_req  = 1'b1;
        tick();
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mask[i] = last_en;
        end
        check("t3_len0_pattern", 32'(mask), 32'h01);

        // Re-step during a 3-cycle burst is ignored
        bus.burst_len = 8'd3;
        bus.step_req  = 1'b0;
        tick();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        mask = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            mask[i] = last_en;
            if (i == 0) bus.step_req = 1'b1;
        end
        check("t3_restep_pattern", 32'(mask), 32'h07);
        check("t3_cycle_count", bus.cycle_count, 32'd9);

        // Breakpoint on comparator 1 at 0x40, starting from pc 0x24
        bus.bkpt_en   = 2'b10;
        bus.bkpt_addr = {32'h0000_0040, 32'h0000_0000};
        bus.run_req   = 1'b1;
        tick();
        for (int i = 0; i < 30 && !bus.halted; i++) tick();
        check("t4_halt_pc", pc_m, 32'h40);
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_bkpt_hit", 32'(bus.bkpt_hit), 32'h2);
        check("t4_cycle_count", bus.cycle_count, 32'd16);
        for (int i = 0; i < 3; i++) tick();
        check("t4_hold_no_resume", pc_m, 32'h40);
        bus.run_req = 1'b0;
        tick();
        bus.run_req = 1'b1;
        tick();
        check("t4_resume_hit_clr", 32'(bus.bkpt_hit), 32'd0);
        check("t4_resume_running", 32'(bus.halted), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        bus.run_req = 1'b0;
        tick();
        check("t4_resume_pc", pc_m, 32'h50);
        check("t4_stop_halted", 32'(bus.halted), 32'd1);
        check("t4_cycle_count2", bus.cycle_count, 32'd20);

        // rst_req mid-burst after 3 of 8 cycles
        bus.bkpt_en   = 2'b00;
        bus.burst_len = 8'd8;
        bus.step_req  = 1'b0;
        tick();
        bus.step_req = 1'b1;
        tick();
        tick();
        tick();
        bus.rst_req = 1'b1;
        tick();
        bus.rst_req = 1'b0;
        check("t5_halted", 32'(bus.halted), 32'd1);
        check("t5_cpu_en", 32'(bus.cpu_en), 32'd0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.cpu_rst) cnt_a++;
            if (last_en) cnt_b++;
        end
        check("t5_cpu_rst_len", cnt_a, 32'd16);
        check("t5_no_residual_en", cnt_b, 32'd0);
        check("t5_cycle_count", bus.cycle_count, 32'd23);
        check("t5_halted_after", 32'(bus.halted), 32'd1);

        // Simultaneous rises: RUN wins over a 1-cycle burst
        bus.burst_len = 8'd1;
        bus.step_req  = 1'b0;
        tick();
        bus.step_req = 1'b1;
        bus.run_req  = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("both_rise_run_wins", 32'(bus.halted), 32'd0);
        bus.run_req = 1'b0;
        tick();
        check("both_rise_stop", bus.cycle_count, 32'd27);

        // Counter wrap from a preloaded all-ones value
        force dut.r_cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle_count;
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        tick();
        check("t6_wrap", bus.cycle_count, 32'd0);
        check("t6_halted", 32'(bus.halted), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
